// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, waits out the instruction-memory
// latency, latches two words and holds them until the decoder moves the PC.
module fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cnt_en,
  input  logic        pc_sload,
  input  logic [15:0] new_pc,
  input  logic        two_word,
  input  logic        stall,
  input  logic [15:0] imem_q1,
  input  logic [15:0] imem_q2,
  output logic [15:0] imem_addr1,
  output logic [15:0] imem_addr2,
  output logic [15:0] pc,
  output logic [15:0] instruction1,
  output logic [15:0] instruction2,
  output logic        instr_valid
);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  // Last wait count of a fetch; read data is valid once the count reaches it.
  localparam logic [1:0] LAST_CNT = 2'(MEM_LATENCY);

  state_t      state_r, state_s;
  logic [1:0]  cnt_r, cnt_s;
  logic [15:0] pc_r, pc_s;
  logic [15:0] instr1_r, instr1_s;
  logic [15:0] instr2_r, instr2_s;
  logic        valid_r, valid_s;

  // Next-state and next-value logic for the fetch/exec sequencer.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    pc_s     = pc_r;
    instr1_s = instr1_r;
    instr2_s = instr2_r;
    valid_s  = valid_r;
    case (state_r)
      FETCH: begin
        valid_s = 1'b0;
        if (cnt_r == LAST_CNT) begin
          instr1_s = imem_q1;
          instr2_s = imem_q2;
          valid_s  = 1'b1;
          cnt_s    = 2'd0;
          state_s  = EXEC;
        end else begin
          cnt_s = cnt_r + 2'd1;
        end
      end
      EXEC: begin
        // Jump takes priority over sequential advance; stall freezes both.
        if (stall) begin
          state_s = EXEC;
        end else if (pc_sload) begin
          pc_s    = new_pc;
          valid_s = 1'b0;
          state_s = FETCH;
        end else if (cnt_en) begin
          pc_s    = pc_r + (two_word ? 16'd2 : 16'd1);
          valid_s = 1'b0;
          state_s = FETCH;
        end else begin
          state_s = EXEC;
        end
      end
      default: begin
        state_s = FETCH;
        cnt_s   = 2'd0;
        valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= FETCH;
      cnt_r    <= 2'd0;
      pc_r     <= RESET_PC;
      instr1_r <= 16'h0000;
      instr2_r <= 16'h0000;
      valid_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      pc_r     <= pc_s;
      instr1_r <= instr1_s;
      instr2_r <= instr2_s;
      valid_r  <= valid_s;
    end
  end

  assign imem_addr1   = pc_r;
  assign imem_addr2   = pc_r + 16'd1;
  assign pc           = pc_r;
  assign instruction1 = instr1_r;
  assign instruction2 = instr2_r;
  assign instr_valid  = valid_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit at MEM_LATENCY 1 and 3,
// each instance paired with a memory model holding word[k] = 16'hA000 + k.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset1, reset3;
  logic        cnt_en, pc_sload, two_word, stall;
  logic [15:0] new_pc;

  logic [15:0] q1_a, q2_a, addr1_a, addr2_a, pc_a, ins1_a, ins2_a;
  logic        valid_a;
  logic [15:0] q1_b, q2_b, addr1_b, addr2_b, pc_b, ins1_b, ins2_b;
  logic        valid_b;
  logic [15:0] m1_0, m2_0, m1_1, m2_1;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(16'h0000), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset1), .cnt_en(cnt_en), .pc_sload(pc_sload),
    .new_pc(new_pc), .two_word(two_word), .stall(stall),
    .imem_q1(q1_a), .imem_q2(q2_a), .imem_addr1(addr1_a), .imem_addr2(addr2_a),
    .pc(pc_a), .instruction1(ins1_a), .instruction2(ins2_a), .instr_valid(valid_a)
  );

  fetch_unit #(.RESET_PC(16'h0000), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset3), .cnt_en(cnt_en), .pc_sload(pc_sload),
    .new_pc(new_pc), .two_word(two_word), .stall(stall),
    .imem_q1(q1_b), .imem_q2(q2_b), .imem_addr1(addr1_b), .imem_addr2(addr2_b),
    .pc(pc_b), .instruction1(ins1_b), .instruction2(ins2_b), .instr_valid(valid_b)
  );

  // One-cycle memory for dut1
  always @(posedge clk) begin
    q1_a <= 16'hA000 + addr1_a;
    q2_a <= 16'hA000 + addr2_a;
  end

  // Three-cycle memory for dut3
  always @(posedge clk) begin
    m1_0 <= 16'hA000 + addr1_b;
    m2_0 <= 16'hA000 + addr2_b;
    m1_1 <= m1_0;
    m2_1 <= m2_0;
    q1_b <= m1_1;
    q2_b <= m2_1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset1 = 1'b1; reset3 = 1'b1;
    cnt_en = 1'b0; pc_sload = 1'b0; two_word = 1'b0; stall = 1'b0;
    new_pc = 16'h0000;
    tick(); tick();
    check("rst_pc", pc_a, 16'h0000);
    check("rst_valid", {15'd0, valid_a}, 16'd0);
    check("rst_ins1", ins1_a, 16'h0000);
    check("rst_ins2", ins2_a, 16'h0000);

    // First fetch after reset
    reset1 = 1'b0;
    check("f0_addr1", addr1_a, 16'h0000);
    check("f0_addr2", addr2_a, 16'h0001);
    check("f0_valid", {15'd0, valid_a}, 16'd0);
    tick();
    check("f1_valid", {15'd0, valid_a}, 16'd0);
    check("f1_addr1", addr1_a, 16'h0000);
    tick();
    check("f2_valid", {15'd0, valid_a}, 16'd1);
    check("f2_ins1", ins1_a, 16'hA000);
    check("f2_ins2", ins2_a, 16'hA001);

    // Sequential advance by one
    cnt_en = 1'b1; two_word = 1'b0;
    tick();
    cnt_en = 1'b0;
    check("adv1_pc", pc_a, 16'h0001);
    check("adv1_valid0", {15'd0, valid_a}, 16'd0);
    tick();
    check("adv1_valid1", {15'd0, valid_a}, 16'd0);
    tick();
    check("adv1_valid2", {15'd0, valid_a}, 16'd1);
    check("adv1_ins1", ins1_a, 16'hA001);
    check("adv1_ins2", ins2_a, 16'hA002);

    // Two-word advance
    cnt_en = 1'b1; two_word = 1'b1;
    tick();
    cnt_en = 1'b0; two_word = 1'b0;
    check("adv2_pc", pc_a, 16'h0003);
    tick(); tick();
    check("adv2_valid", {15'd0, valid_a}, 16'd1);
    check("adv2_ins1", ins1_a, 16'hA003);

    // Jump beats advance; controls during FETCH are ignored
    pc_sload = 1'b1; cnt_en = 1'b1; new_pc = 16'h0040;
    tick();
    check("jmp_pc", pc_a, 16'h0040);
    check("jmp_addr1", addr1_a, 16'h0040);
    check("jmp_addr2", addr2_a, 16'h0041);
    new_pc = 16'h1234; two_word = 1'b1;
    tick();
    pc_sload = 1'b0; cnt_en = 1'b0; two_word = 1'b0;
    check("fetch_ignore_pc", pc_a, 16'h0040);
    check("fetch_ignore_valid", {15'd0, valid_a}, 16'd0);
    tick();
    check("jmp_valid", {15'd0, valid_a}, 16'd1);
    check("jmp_ins1", ins1_a, 16'hA040);
    check("jmp_pc_held", pc_a, 16'h0040);

    // Wrap-around at the top of the address space
    pc_sload = 1'b1; new_pc = 16'hFFFF;
    tick();
    pc_sload = 1'b0;
    check("wrap_pc", pc_a, 16'hFFFF);
    check("wrap_addr2", addr2_a, 16'h0000);
    tick(); tick();
    check("wrap_ins1", ins1_a, 16'h9FFF);
    check("wrap_ins2", ins2_a, 16'hA000);
    cnt_en = 1'b1; two_word = 1'b1;
    tick();
    cnt_en = 1'b0; two_word = 1'b0;
    check("wrap_adv_pc", pc_a, 16'h0001);
    tick(); tick();
    check("wrap_adv_ins1", ins1_a, 16'hA001);

    // Stall holds PC and valid despite cnt_en
    stall = 1'b1; cnt_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_pc", pc_a, 16'h0001);
      check("stall_valid", {15'd0, valid_a}, 16'd1);
    end
    stall = 1'b0;
    tick();
    cnt_en = 1'b0;
    check("unstall_pc", pc_a, 16'h0002);
    check("unstall_valid", {15'd0, valid_a}, 16'd0);
    tick(); tick();
    // Idle EXEC holds
    tick(); tick();
    check("idle_pc", pc_a, 16'h0002);
    check("idle_valid", {15'd0, valid_a}, 16'd1);
    check("idle_ins1", ins1_a, 16'hA002);

    // MEM_LATENCY = 3 instance
    reset3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("l3_fetch_valid", {15'd0, valid_b}, 16'd0);
      tick();
    end
    check("l3_valid", {15'd0, valid_b}, 16'd1);
    check("l3_ins1", ins1_b, 16'hA000);
    check("l3_ins2", ins2_b, 16'hA001);
    cnt_en = 1'b1;
    tick();
    cnt_en = 1'b0;
    check("l3_adv_pc", pc_b, 16'h0001);
    tick();
    reset3 = 1'b1;
    tick();
    reset3 = 1'b0;
    check("l3_rst_pc", pc_b, 16'h0000);
    check("l3_rst_valid", {15'd0, valid_b}, 16'd0);
    check("l3_rst_ins1", ins1_b, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      check("l3_refetch_valid", {15'd0, valid_b}, 16'd0);
      tick();
    end
    check("l3_refetch_done", {15'd0, valid_b}, 16'd1);
    check("l3_refetch_ins1", ins1_b, 16'hA000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
